frv_dmem_responder: RTL and testbench

- Data-memory responder (target side) for the core's dmem request/stall interface.
- Used as the SRAM-backed data memory in core-level simulation and as the on-chip scratch RAM in FPGA builds.
- Accepts one access at a time and inserts a configurable number of wait states via dmem_stall.
- Performs byte-strobed writes and full-word reads, and flags out-of-range or illegal-strobe accesses on dmem_error.

---
 rtl/frv_dmem_if.sv | 21 ++
 rtl/frv_dmem_responder.sv | 124 ++++++++++++
 tb/tb_frv_dmem_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/frv_dmem_if.sv
// Data-memory request/stall bus between the core (master) and a memory target (slave).
interface frv_dmem_if;
   logic        dmem_cen;
   logic        dmem_wen;
   logic [3:0]  dmem_strb;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_stall;
   logic        dmem_error;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_cen, dmem_wen, dmem_strb, dmem_addr, dmem_wdata,
      input  dmem_stall, dmem_error, dmem_rdata
   );

   modport slave (
      input  dmem_cen, dmem_wen, dmem_strb, dmem_addr, dmem_wdata,
      output dmem_stall, dmem_error, dmem_rdata
   );
endinterface

// File: rtl/frv_dmem_responder.sv
// Single-outstanding data-memory target with programmable wait states,
// byte-strobed writes, range/strobe error reporting and a sticky
// protocol-violation flag. Memory contents survive reset.
module frv_dmem_responder #(
   parameter logic [31:0] MEM_BASE    = 32'h0002_0000,
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        g_clk,
   input  logic        g_reset,
   frv_dmem_if.slave   bus,
   output logic        viol_sticky
);

   localparam logic [32:0] MEM_BYTES = 33'(1) << (DEPTH_LOG2 + 2);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [31:0]           l_addr;
   logic [31:0]           l_wdata;
   logic [3:0]            l_strb;
   logic                  l_wen;
   logic                  l_err;
   logic [31:0]           rdata_q;
   logic                  error_q;
   logic [31:0]           mem [2**DEPTH_LOG2];

   logic                  req_err;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [DEPTH_LOG2-1:0] l_idx;
   logic                  changed;
   logic                  in_txn;

   // Only single bytes, aligned halfwords and the full word are legal strobes.
   function automatic logic strb_ok(input logic [3:0] s);
      case (s)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: strb_ok = 1'b1;
         default:                   strb_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off      = a - MEM_BASE;
      word_idx = off[DEPTH_LOG2+1:2];
   endfunction

   // Request decode for the incoming access (used when latching in IDLE).
   always_comb begin
      req_err = (bus.dmem_addr < MEM_BASE) ||
                ({1'b0, bus.dmem_addr - MEM_BASE} >= MEM_BYTES) ||
                (bus.dmem_wen && !strb_ok(bus.dmem_strb));
      req_idx = word_idx(bus.dmem_addr);
      l_idx   = word_idx(l_addr);
      in_txn  = (state == WAIT) || (state == RESP);
      changed = (bus.dmem_addr != l_addr) || (bus.dmem_wen != l_wen) ||
                (bus.dmem_strb != l_strb) || (bus.dmem_wdata != l_wdata);
   end

   // Stall is forced during reset so nothing can complete while it is held.
   assign bus.dmem_stall = bus.dmem_cen && ((state != RESP) || g_reset);
   assign bus.dmem_error = error_q;
   assign bus.dmem_rdata = rdata_q;

   // Access sequencing: latch in IDLE, count wait states, register the response on RESP entry.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state       <= IDLE;
         cnt         <= '0;
         l_addr      <= '0;
         l_wdata     <= '0;
         l_strb      <= '0;
         l_wen       <= 1'b0;
         l_err       <= 1'b0;
         rdata_q     <= '0;
         error_q     <= 1'b0;
         viol_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.dmem_cen) begin
               l_addr  <= bus.dmem_addr;
               l_wdata <= bus.dmem_wdata;
               l_strb  <= bus.dmem_strb;
               l_wen   <= bus.dmem_wen;
               l_err   <= req_err;
               if (WAIT_CYCLES == 0) begin
                  state   <= RESP;
                  rdata_q <= req_err ? '0 : mem[req_idx];
                  error_q <= req_err;
               end else begin
                  cnt   <= 4'(WAIT_CYCLES - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (!bus.dmem_cen) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state   <= RESP;
                  rdata_q <= l_err ? '0 : mem[l_idx];
                  error_q <= l_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
         if (in_txn && (!bus.dmem_cen || changed))
            viol_sticky <= 1'b1;
      end
   end

   // Byte-lane write at the closing edge of RESP; a dropped or erroring access writes nothing.
   always_ff @(posedge g_clk) begin
      if (!g_reset && (state == RESP) && bus.dmem_cen && l_wen && !l_err) begin
         for (int i = 0; i < 4; i++)
            if (l_strb[i]) mem[l_idx][8*i +: 8] <= l_wdata[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Directed bench: two responders (0 and 3 wait states) behind one stimulus set,
// a vector table for single accesses plus hand sequences for timing and violations.
module tb_frv_dmem_responder;

   localparam logic [31:0] MB = 32'h0002_0000;

   logic        clk = 1'b0;
   logic        g_reset = 1'b1;
   logic        sel = 1'b0;           // 0 -> zero-wait DUT, 1 -> 3-wait DUT
   logic        cen = 1'b0, wen = 1'b0;
   logic [3:0]  strb = 4'h0;
   logic [31:0] addr = '0, wdata = '0;
   logic        viol0, viol3;
   logic        stall, error, viol;
   logic [31:0] rdata;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   frv_dmem_if if0 ();
   frv_dmem_if if3 ();

   assign if0.dmem_cen   = cen & ~sel;
   assign if3.dmem_cen   = cen & sel;
   assign if0.dmem_wen   = wen;
   assign if3.dmem_wen   = wen;
   assign if0.dmem_strb  = strb;
   assign if3.dmem_strb  = strb;
   assign if0.dmem_addr  = addr;
   assign if3.dmem_addr  = addr;
   assign if0.dmem_wdata = wdata;
   assign if3.dmem_wdata = wdata;

   assign stall = sel ? if3.dmem_stall : if0.dmem_stall;
   assign error = sel ? if3.dmem_error : if0.dmem_error;
   assign rdata = sel ? if3.dmem_rdata : if0.dmem_rdata;
   assign viol  = sel ? viol3 : viol0;

   frv_dmem_responder #(.MEM_BASE(MB), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
      .g_clk(clk), .g_reset(g_reset), .bus(if0.slave), .viol_sticky(viol0));

   frv_dmem_responder #(.MEM_BASE(MB), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut3 (
      .g_clk(clk), .g_reset(g_reset), .bus(if3.slave), .viol_sticky(viol3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      g_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 g_reset = 1'b0;
   endtask

   // One complete access; returns stall cycle count and the completion-cycle outputs.
   task automatic access(input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, output int nst, output logic e,
                         output logic [31:0] r);
      @(posedge clk);
      #1;
      cen = 1'b1; wen = w; strb = s; addr = a; wdata = d;
      #1;
      nst = 0;
      while (stall && nst < 40) begin
         @(posedge clk);
         #2;
         nst++;
      end
      if (nst >= 40) chk("access_timeout", 32'(nst), 32'd0);
      e = error;
      r = rdata;
      @(posedge clk);
      #1 cen = 1'b0;
   endtask

   typedef struct {
      logic        sel;
      logic        wen;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        e_err;
      logic        chk_rd;
      logic [31:0] e_rd;
      int          e_st;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int          nst;
      logic        e;
      logic [31:0] r;
      int          first, second;
      logic [31:0] r2;

      vecs = '{
         '{0, 1, 4'b1111, MB + 0,       32'hA5A5A5A5, 0, 0, 32'h0,        1},
         '{0, 1, 4'b1111, MB + 8,       32'hDEADBEEF, 0, 0, 32'h0,        1},
         '{0, 0, 4'b0000, MB + 8,       32'h0,        0, 1, 32'hDEADBEEF, 1},
         '{0, 1, 4'b1111, MB + 12,      32'h11223344, 0, 0, 32'h0,        1},
         '{0, 1, 4'b0010, MB + 12,      32'h0000AA00, 0, 0, 32'h0,        1},
         '{0, 0, 4'b0000, MB + 12,      32'h0,        0, 1, 32'h1122AA44, 1},
         '{0, 1, 4'b1111, MB + 32'h1000, 32'h77777777, 1, 0, 32'h0,       1},
         '{0, 0, 4'b0000, MB + 0,       32'h0,        0, 1, 32'hA5A5A5A5, 1},
         '{0, 0, 4'b0000, MB - 4,       32'h0,        1, 1, 32'h0,        1},
         '{0, 1, 4'b0101, MB + 12,      32'hFFFFFFFF, 1, 0, 32'h0,        1},
         '{0, 1, 4'b0000, MB + 12,      32'hFFFFFFFF, 0, 0, 32'h0,        1},
         '{0, 0, 4'b0000, MB + 12,      32'h0,        0, 1, 32'h1122AA44, 1},
         '{0, 1, 4'b1100, MB + 12,      32'hBBCC0000, 0, 0, 32'h0,        1},
         '{0, 0, 4'b0000, MB + 12,      32'h0,        0, 1, 32'hBBCCAA44, 1},
         '{0, 1, 4'b1111, MB + 32'hFFC, 32'h0BADF00D, 0, 0, 32'h0,        1},
         '{0, 0, 4'b0000, MB + 32'hFFC, 32'h0,        0, 1, 32'h0BADF00D, 1},
         '{1, 1, 4'b1111, MB + 16,      32'h12345678, 0, 0, 32'h0,        4},
         '{1, 1, 4'b1111, MB + 8,       32'h87654321, 0, 0, 32'h0,        4},
         '{1, 0, 4'b0000, MB + 16,      32'h0,        0, 1, 32'h12345678, 4},
         '{1, 0, 4'b0000, MB + 32'h1004, 32'h0,       1, 1, 32'h0,        4}
      };

      // Reset state
      @(posedge clk);
      #1;
      sel = 0; #1; chk("rst_rdata0", rdata, 32'h0); chk("rst_err0", 32'(error), 32'h0);
      chk("rst_viol0", 32'(viol), 32'h0);
      sel = 1; #1; chk("rst_rdata3", rdata, 32'h0); chk("rst_viol3", 32'(viol), 32'h0);
      cen = 1'b1; #1; chk("rst_stall_follows_cen", 32'(stall), 32'h1);
      cen = 1'b0; #1; chk("rst_stall_low", 32'(stall), 32'h0);
      @(posedge clk);
      #1 g_reset = 1'b0;

      // Vector table
      foreach (vecs[i]) begin
         sel = vecs[i].sel;
         access(vecs[i].wen, vecs[i].strb, vecs[i].addr, vecs[i].wdata, nst, e, r);
         chk($sformatf("v%0d_stalls", i), 32'(nst), 32'(vecs[i].e_st));
         chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].e_err));
         if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), r, vecs[i].e_rd);
      end

      // Back-to-back reads on 3-wait DUT: completions 5 cycles apart
      sel = 1;
      @(posedge clk);
      #1;
      cen = 1'b1; wen = 1'b0; strb = 4'h0; addr = MB + 16; wdata = '0;
      first = 0; second = 0; r2 = '0;
      for (int k = 1; k <= 10; k++) begin
         #1;
         if (!stall) begin
            if (first == 0) first = k;
            else begin second = k; r2 = rdata; end
         end
         @(posedge clk);
         #1;
      end
      cen = 1'b0;
      chk("b2b_first", 32'(first), 32'd5);
      chk("b2b_second", 32'(second), 32'd10);
      chk("b2b_rdata", r2, 32'h12345678);

      // Reset in WAIT of a write: write dropped, no violation
      access(1'b1, 4'b1111, MB + 20, 32'h55667788, nst, e, r);
      @(posedge clk);
      #1;
      cen = 1'b1; wen = 1'b1; strb = 4'b1111; addr = MB + 20; wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 g_reset = 1'b1;
      #1 chk("rstwait_stall", 32'(stall), 32'h1);
      @(posedge clk);
      #1; g_reset = 1'b0; cen = 1'b0;
      #1;
      chk("rstwait_viol", 32'(viol), 32'h0);
      chk("rstwait_rdata", rdata, 32'h0);
      access(1'b0, 4'h0, MB + 20, 32'h0, nst, e, r);
      chk("rstwait_old", r, 32'h55667788);
      chk("rstwait_stalls", 32'(nst), 32'd4);

      // cen dropped in WAIT
      @(posedge clk);
      #1;
      cen = 1'b1; wen = 1'b0; addr = MB + 16;
      @(posedge clk);
      #1;
      chk("drop_viol_before", 32'(viol), 32'h0);
      cen = 1'b0;
      @(posedge clk);
      #2 chk("drop_viol_set", 32'(viol), 32'h1);
      repeat (3) @(posedge clk);
      #2 chk("drop_viol_sticky", 32'(viol), 32'h1);
      do_reset();
      #1 chk("drop_viol_cleared", 32'(viol), 32'h0);

      // Address changed during stall: flag set, latched address still used
      @(posedge clk);
      #1;
      cen = 1'b1; wen = 1'b0; addr = MB + 16;
      @(posedge clk);
      #1 addr = MB + 8;
      @(posedge clk);
      #2 chk("chg_viol_set", 32'(viol), 32'h1);
      nst = 0;
      while (stall && nst < 20) begin
         @(posedge clk);
         #2;
         nst++;
      end
      chk("chg_complete", 32'(stall), 32'h0);
      chk("chg_latched_rdata", rdata, 32'h12345678);
      @(posedge clk);
      #1 cen = 1'b0;
      repeat (2) @(posedge clk);
      #2 chk("chg_viol_sticky", 32'(viol), 32'h1);
      do_reset();
      #1 chk("chg_viol_cleared", 32'(viol), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
